loop_step_sequencer: RTL and testbench
======================================

LOOP_STEP_SEQUENCER -- requirements
Module: loop_step_sequencer

Interface
REQ-001 Parameter: IDX_W, default 4, width of loop index and limit.
REQ-002 Clock is clk and reset is rst; there is one clock, and reset is asynchronous and active-high.
REQ-003 Ports SHALL be as follows, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start_valid  input  1  request to run one loop.
- start_ready  output  1  sequencer can accept a request.
- limit  input  IDX_W  iteration count; sampled on accept.
- stall  input  1  downstream holds the current index.
- index  output  IDX_W  current loop index.
- index_valid  output  1  index is a live iteration.
- index_last  output  1  index == latched limit-1.
- done  output  1  one-cycle pulse at loop end.
- for_completed  output  1  sticky: last accepted loop finished.
- busy  output  1  not in IDLE.

Function
REQ-004 The FSM SHALL have states IDLE, RUN and DONE, encoded with the package enum.
REQ-005 start_ready SHALL be 1 only in IDLE; start_valid outside IDLE SHALL be ignored without effect.
REQ-006 On accept (start_valid && start_ready) the block SHALL latch limit, clear for_completed and index, and transition:
- to RUN if limit != 0;
- to DONE if limit == 0.
REQ-007 In RUN, index_valid SHALL be 1.
- index SHALL start at 0 and increment by 1 on each cycle with stall=0.
- index SHALL hold while stall=1.
REQ-008 In RUN, when index == limit-1 and stall=0, the FSM SHALL go to DONE; index SHALL hold its final value and index_valid SHALL drop next cycle.
REQ-009 DONE SHALL last exactly one cycle, with:
- done=1, index_valid=0, for_completed set on exit;
- then a return to IDLE.
REQ-010 Latency: the first index is valid 1 cycle after accept; a loop with no stalls takes limit+2 cycles from accept to IDLE.
REQ-011 The index counter SHALL never wrap; the maximum limit 2^IDX_W-1 yields final index 2^IDX_W-2.
REQ-012 index_last SHALL be combinational from index and the latched limit, qualified by index_valid.
REQ-013 for_completed SHALL remain 1 from DONE exit until the next accept.
REQ-014 stall SHALL have no effect outside RUN; stall in the same cycle as the final index SHALL delay DONE.

Reset
REQ-015 While rst=1, regardless of state:
- FSM = IDLE, index = 0, latched limit = 0;
- index_valid, done, for_completed, busy = 0;
- start_ready = 1 once reset releases.
REQ-016 Reset mid-loop SHALL abandon the loop with no done pulse, and for_completed SHALL stay 0.

Configuration
REQ-017 Macro LOOP_SEQ_ABORT_EN SHALL add input abort (1 bit).
- With the macro: abort=1 in RUN forces DONE next cycle, done pulses, and for_completed stays 0.
- Without the macro: there is no abort port and behaviour is as per REQ-004..014.

Structure
REQ-018 Package loop_seq_pkg SHALL hold:
- the IDX_W default constant;
- the state enum loop_state_t {IDLE, RUN, DONE};
- the shared loop_if interface definition with Ctrl/Report modports (index, done).
REQ-019 The block SHALL drive a loop_if instance through the Ctrl modport, mirroring index and done, so that downstream consumers attach via Report.
REQ-020 One sub-module, loop_step_counter, SHALL implement the loadable, stallable index counter with its terminal compare; the FSM stays in the top level.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- limit=3, no stall: accept at cycle 0 -> index 0,1,2 valid in cycles 1-3; index_last in cycle 3; done in cycle 4; for_completed=1 from cycle 5.
- limit=0: accept -> no index_valid; done 1 cycle after accept; for_completed=1.
- limit=4, stall=1 during index=2 for 3 cycles -> index holds at 2 for 4 cycles total; done 3 cycles late.
- limit=15 -> final index 14; no wrap; done once.
- limit=5, start_valid held high throughout -> second accept only in IDLE after DONE; the limit change mid-loop is ignored.
- rst pulsed at index=2 of limit=6 -> all outputs 0 immediately; no done pulse; the next accept runs cleanly.

Source files
------------

// File: rtl/loop_seq_pkg.sv
// Shared types and constants for the loop step sequencer.
// Optional abort input is enabled with LOOP_SEQ_ABORT_EN.
package loop_seq_pkg;

    localparam int IDX_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } loop_state_t;

endpackage

// File: rtl/loop_if.sv
// Report bus carrying the live loop index and the end-of-loop pulse.
// Ctrl drives it; downstream consumers attach through Report.
interface loop_if #(
    parameter int IDX_W = loop_seq_pkg::IDX_W_DEFAULT
);

    logic [IDX_W-1:0] index;
    logic             done;

    modport Ctrl   (output index, output done);
    modport Report (input  index, input  done);

endinterface

// File: rtl/loop_step_counter.sv
// Loadable, stallable loop index counter with its terminal compare.
// Load clears the index and latches the limit; advance steps the index by one.
module loop_step_counter #(
    parameter int IDX_W = loop_seq_pkg::IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [IDX_W-1:0] load_limit,
    input  logic             advance,
    output logic [IDX_W-1:0] index,
    output logic             is_last
);

    logic [IDX_W-1:0] limit_q;

    // The caller never advances past the terminal index, so the counter cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index   <= '0;
            limit_q <= '0;
        end else if (load) begin
            index   <= '0;
            limit_q <= load_limit;
        end else if (advance) begin
            index <= index + IDX_W'(1);
        end
    end

    assign is_last = (index == (limit_q - IDX_W'(1)));

endmodule

// File: rtl/loop_step_sequencer.sv
// Loop step sequencer: IDLE/RUN/DONE control around a stallable index counter.
// Define LOOP_SEQ_ABORT_EN to add the abort input.
module loop_step_sequencer
    import loop_seq_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [IDX_W-1:0] limit,
    input  logic             stall,
`ifdef LOOP_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             index_last,
    output logic             done,
    output logic             for_completed,
    output logic             busy,
    loop_if.Ctrl             report
);

    loop_state_t state;
    logic        accept;
    logic        advance;
    logic        cnt_last;
    logic        abort_req;
    logic        aborted;

`ifdef LOOP_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign start_ready = (state == IDLE);
    assign accept      = start_valid && start_ready;
    assign advance     = (state == RUN) && !stall && !cnt_last && !abort_req;
    assign index_last  = index_valid && cnt_last;

    loop_step_counter #(
        .IDX_W(IDX_W)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_limit(limit),
        .advance   (advance),
        .index     (index),
        .is_last   (cnt_last)
    );

    // A stalled final index keeps the FSM in RUN; an aborted loop still pulses done
    // but leaves for_completed clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            index_valid   <= 1'b0;
            done          <= 1'b0;
            for_completed <= 1'b0;
            busy          <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_valid) begin
                        for_completed <= 1'b0;
                        aborted       <= 1'b0;
                        busy          <= 1'b1;
                        if (limit != '0) begin
                            state       <= RUN;
                            index_valid <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort_req || (cnt_last && !stall)) begin
                        state       <= DONE;
                        index_valid <= 1'b0;
                        done        <= 1'b1;
                        aborted     <= abort_req;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    done          <= 1'b0;
                    busy          <= 1'b0;
                    for_completed <= !aborted;
                end
                default: begin
                    state       <= IDLE;
                    index_valid <= 1'b0;
                    done        <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign report.index = index;
    assign report.done  = done;

endmodule

// File: tb/tb_loop_step_sequencer.sv
// Scoreboard bench for loop_step_sequencer: expected index streams are queued on
// accept and popped by a monitor; directed scenarios add cycle-exact checks.
module tb_loop_step_sequencer;
    import loop_seq_pkg::*;

    localparam int IDX_W = IDX_W_DEFAULT;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_valid;
    logic             start_ready;
    logic [IDX_W-1:0] limit;
    logic             stall;
    logic [IDX_W-1:0] index;
    logic             index_valid;
    logic             index_last;
    logic             done;
    logic             for_completed;
    logic             busy;
`ifdef LOOP_SEQ_ABORT_EN
    logic             abort = 1'b0;
`endif

    loop_if #(.IDX_W(IDX_W)) rpt_bus ();

    loop_step_sequencer #(.IDX_W(IDX_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .limit        (limit),
        .stall        (stall),
`ifdef LOOP_SEQ_ABORT_EN
        .abort        (abort),
`endif
        .index        (index),
        .index_valid  (index_valid),
        .index_last   (index_last),
        .done         (done),
        .for_completed(for_completed),
        .busy         (busy),
        .report       (rpt_bus.Ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int idx;
        bit last;
    } exp_item_t;

    exp_item_t exp_q[$];
    int        checks = 0;
    int        passes = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A loop of limit L must deliver indices 0..L-1 in order, the last flagged, then one done.
    task automatic pushLoop(input int lim);
        exp_item_t e;
        for (int i = 0; i < lim; i++) begin
            e.is_done = 1'b0;
            e.idx     = i;
            e.last    = (i == lim - 1);
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.idx     = 0;
        e.last    = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 200; n++) begin
            if (!busy) return;
            tick();
        end
        checkOutput("idle timeout", busy, 0);
    endtask

    // Raises start_valid for one cycle with the given limit; returns in cycle 1 after accept.
    task automatic applyStimulus(input int lim);
        waitIdle();
        start_valid = 1'b1;
        limit       = IDX_W'(lim);
        pushLoop(lim);
        tick();
        start_valid = 1'b0;
    endtask

    task automatic runTimed(input string name, input int lim, input int stall_at, input int stall_len);
        int phase;
        int exp_idx;
        int stalled;
        bit s;
        applyStimulus(lim);
        phase   = (lim == 0) ? 1 : 0;
        exp_idx = 0;
        stalled = 0;
        for (int c = 1; c <= lim + stall_len + 2; c++) begin
            case (phase)
                0: begin
                    checkOutput({name, " index_valid"}, index_valid, 1);
                    checkOutput({name, " index"}, index, exp_idx);
                    checkOutput({name, " index_last"}, index_last, (exp_idx == lim - 1) ? 1 : 0);
                    s = (exp_idx == stall_at) && (stalled < stall_len);
                    stall = s;
                    if (s) stalled++;
                    else if (exp_idx == lim - 1) phase = 1;
                    else exp_idx++;
                end
                1: begin
                    checkOutput({name, " done"}, done, 1);
                    checkOutput({name, " valid in done"}, index_valid, 0);
                    checkOutput({name, " fc in done"}, for_completed, 0);
                    stall = 1'b1;
                    phase = 2;
                end
                default: begin
                    checkOutput({name, " for_completed"}, for_completed, 1);
                    checkOutput({name, " busy"}, busy, 0);
                    checkOutput({name, " start_ready"}, start_ready, 1);
                    checkOutput({name, " done cleared"}, done, 0);
                    stall = 1'b0;
                end
            endcase
            if (c < lim + stall_len + 2) tick();
        end
        stall = 1'b0;
    endtask

    // start_valid held through a whole loop: only the IDLE cycle after DONE accepts.
    task automatic runHeld();
        waitIdle();
        start_valid = 1'b1;
        limit       = IDX_W'(5);
        pushLoop(5);
        pushLoop(2);
        tick();
        limit = IDX_W'(2);
        for (int c = 2; c <= 5; c++) tick();
        checkOutput("held idx4", index, 4);
        checkOutput("held last", index_last, 1);
        tick();
        checkOutput("held done", done, 1);
        checkOutput("held ready in done", start_ready, 0);
        tick();
        checkOutput("held idle ready", start_ready, 1);
        checkOutput("held idle fc", for_completed, 1);
        tick();
        checkOutput("held re-accept valid", index_valid, 1);
        checkOutput("held re-accept index", index, 0);
        checkOutput("held re-accept fc", for_completed, 0);
        start_valid = 1'b0;
        waitIdle();
    endtask

    task automatic runReset();
        applyStimulus(6);
        tick();
        tick();
        checkOutput("rst pre index", index, 2);
        rst = 1'b1;
        exp_q.delete();
        #1;
        checkOutput("rst index", index, 0);
        checkOutput("rst valid", index_valid, 0);
        checkOutput("rst last", index_last, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst fc", for_completed, 0);
        checkOutput("rst busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post rst fc", for_completed, 0);
        checkOutput("post rst done", done, 0);
        checkOutput("post rst ready", start_ready, 1);
        runTimed("after rst", 3, -1, 0);
    endtask

    task automatic runRandom(input int iters);
        int lim;
        int cycles;
        int stall_cnt;
        for (int it = 0; it < iters; it++) begin
            lim = $urandom_range(0, 15);
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            applyStimulus(lim);
            cycles    = 1;
            stall_cnt = 0;
            while (busy && cycles < 100) begin
                stall = ($urandom_range(0, 2) == 0);
                if (index_valid && stall) stall_cnt++;
                tick();
                cycles++;
            end
            stall = 1'b0;
            checkOutput("rand accept-to-idle", cycles, lim + 2 + stall_cnt);
        end
    endtask

    // Monitor: every consumed index and every done pulse must match the queue head.
    always @(negedge clk) begin
        exp_item_t e;
        if (!rst) begin
            if (index_valid && !stall) begin
                checkOutput("sb pending index", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("sb kind index", e.is_done ? 1 : 0, 0);
                    checkOutput("sb index", index, e.idx);
                    checkOutput("sb bus index", rpt_bus.index, e.idx);
                    checkOutput("sb index_last", index_last, e.last ? 1 : 0);
                end
            end
            if (done) begin
                checkOutput("sb pending done", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("sb kind done", e.is_done ? 1 : 0, 1);
                    checkOutput("sb bus done", rpt_bus.done, 1);
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        start_valid = 1'b0;
        limit       = '0;
        stall       = 1'b0;
        #1;
        checkOutput("reset index", index, 0);
        checkOutput("reset valid", index_valid, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset fc", for_completed, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset ready", start_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        runTimed("lim3", 3, -1, 0);
        runTimed("lim0", 0, -1, 0);
        runTimed("lim4 stall", 4, 2, 3);
        runTimed("lim15", 15, -1, 0);
        runHeld();
        runReset();
        runTimed("lim6 stall", 6, 5, 2);
        runRandom(25);
        tick();
        tick();
        checkOutput("sb drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
